// File: rtl/sync_axi_arbiter.sv
// Round-robin arbiter sharing one AXI master port among per-bank sync requesters.
// Issues AR/AW for the granted request, watches R/W/B for completion, pulses done/err.
module sync_axi_arbiter #(
    parameter int NREQ           = 16,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int TIMEOUT        = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0]                req_wr,
    input  logic [NREQ*AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*8-1:0]              req_len,
    output logic [NREQ-1:0]                gnt,
    output logic [NREQ-1:0]                done,
    output logic [NREQ-1:0]                err,
    output logic                           busy,
    output logic [AXI_ID_WIDTH-1:0]        m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]      m_axi_awaddr,
    output logic [7:0]                     m_axi_awlen,
    output logic [2:0]                     m_axi_awsize,
    output logic [1:0]                     m_axi_awburst,
    output logic                           m_axi_awlock,
    output logic [3:0]                     m_axi_awcache,
    output logic [2:0]                     m_axi_awprot,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    input  logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic                           m_axi_wlast,
    input  logic [AXI_ID_WIDTH-1:0]        m_axi_bid,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]        m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arlock,
    output logic [3:0]                     m_axi_arcache,
    output logic [2:0]                     m_axi_arprot,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]        m_axi_rid,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    input  logic                           m_axi_rready
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_BRESP, S_RDATA, S_FINISH
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [IDX_W-1:0]          r_rr, r_idx, w_sel;
    logic [IDX_W:0]            w_cand;
    logic                      w_found;
    logic                      r_wr, r_fail;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;
    logic [TMR_W-1:0]          r_timer, w_timer_inc;
    logic                      w_timeout, w_r_hs, w_r_bad, w_b_bad, w_w_done;
    logic [AXI_ID_WIDTH-1:0]   w_id;
    logic [NREQ-1:0]           w_onehot;
    logic [AXI_ADDR_WIDTH-1:0] w_slot_addr [NREQ];
    logic [7:0]                w_slot_len  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign w_slot_addr[g] = req_addr[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign w_slot_len[g]  = req_len[g*8 +: 8];
    end

    assign w_id        = AXI_ID_WIDTH'(r_idx);
    assign w_onehot    = NREQ'(1) << r_idx;
    assign w_timer_inc = r_timer + 1'b1;
    assign w_timeout   = (w_timer_inc == TMR_W'(TIMEOUT - 1));
    assign w_r_hs      = m_axi_rvalid & m_axi_rready;
    assign w_r_bad     = m_axi_rresp[1] | (m_axi_rid != w_id);
    assign w_b_bad     = m_axi_bresp[1] | (m_axi_bid != w_id);
    assign w_w_done    = m_axi_wvalid & m_axi_wready & m_axi_wlast;

    assign m_axi_awid    = w_id;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_len;
    assign m_axi_awsize  = 3'($clog2(AXI_STRB_WIDTH));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arid    = w_id;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = 3'($clog2(AXI_STRB_WIDTH));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;

    // First asserted request at or after the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_rr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NREQ)) w_cand = w_cand - (IDX_W+1)'(NREQ);
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        m_axi_awvalid = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_bready  = 1'b0;
        busy          = (r_state != S_IDLE);
        gnt           = busy ? w_onehot : '0;
        done          = '0;
        err           = '0;
        case (r_state)
            S_IDLE:   if (w_found) w_state_nxt = S_ADDR;
            S_ADDR: begin
                m_axi_awvalid = r_wr;
                m_axi_arvalid = !r_wr;
                if (r_wr && m_axi_awready)       w_state_nxt = S_WDATA;
                else if (!r_wr && m_axi_arready) w_state_nxt = S_RDATA;
            end
            S_WDATA: begin
                if (w_timeout)     w_state_nxt = S_FINISH;
                else if (w_w_done) w_state_nxt = S_BRESP;
            end
            S_BRESP: begin
                m_axi_bready = 1'b1;
                if (w_timeout || m_axi_bvalid) w_state_nxt = S_FINISH;
            end
            S_RDATA:  if (w_timeout || (w_r_hs && m_axi_rlast)) w_state_nxt = S_FINISH;
            S_FINISH: begin
                done        = r_fail ? '0 : w_onehot;
                err         = r_fail ? w_onehot : '0;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr    <= '0;
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_timer <= '0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_idx  <= w_sel;
                    r_wr   <= req_wr[w_sel];
                    r_addr <= w_slot_addr[w_sel];
                    r_len  <= w_slot_len[w_sel];
                    r_fail <= 1'b0;
                end
                S_ADDR:  r_timer <= '0;
                S_WDATA: begin
                    r_timer <= w_timer_inc;
                    if (w_timeout) r_fail <= 1'b1;
                end
                S_BRESP: begin
                    r_timer <= w_timer_inc;
                    if (w_timeout || (m_axi_bvalid && w_b_bad)) r_fail <= 1'b1;
                end
                S_RDATA: begin
                    r_timer <= w_timer_inc;
                    // Sticky: a bad middle beat still fails the burst once rlast arrives.
                    if (w_timeout || (w_r_hs && w_r_bad)) r_fail <= 1'b1;
                end
                S_FINISH: r_rr <= (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_axi_arbiter.sv
// Scoreboard bench for sync_axi_arbiter: directed AXI slave stimulus, queued
// expectations for address handshakes and done/err pulses, checked by a monitor.
module tb_sync_axi_arbiter;
    localparam int NREQ = 16;
    localparam int AW   = 16;
    localparam int IW   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req, req_wr, gnt, done, err;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*8-1:0]  req_len;
    logic             busy;
    logic [IW-1:0]    awid, arid, bid, rid;
    logic [AW-1:0]    awaddr, araddr;
    logic [7:0]       awlen, arlen;
    logic [2:0]       awsize, arsize, awprot, arprot;
    logic [1:0]       awburst, arburst, bresp, rresp;
    logic             awlock, arlock;
    logic [3:0]       awcache, arcache;
    logic             awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic             arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [32:0] exp_addr_q[$];
    logic [31:0] exp_resp_q[$];
    logic [32:0] mon_ea;
    logic [31:0] mon_er;

    sync_axi_arbiter #(.NREQ(NREQ), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(32),
                       .AXI_ID_WIDTH(IW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_len(req_len), .gnt(gnt), .done(done), .err(err), .busy(busy),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wlast(wlast),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int idx, input bit w, input logic [AW-1:0] a, input logic [7:0] l);
        req_wr[idx]          = w;
        req_addr[idx*AW +: AW] = a;
        req_len[idx*8 +: 8]  = l;
    endtask

    task automatic exp_ar(input bit w, input int idx, input logic [AW-1:0] a, input logic [7:0] l);
        exp_addr_q.push_back({w, 8'(idx), a, l});
    endtask

    task automatic exp_rsp(input int idx, input bit e);
        logic [31:0] v;
        v = '0;
        if (e) v[16+idx] = 1'b1;
        else   v[idx]    = 1'b1;
        exp_resp_q.push_back(v);
    endtask

    task automatic wait_valid(input bit w, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (w ? awvalid : arvalid) ok = 1'b1;
            else tick();
        end
        chk(w ? "awvalid_seen" : "arvalid_seen", 64'(ok), 64'(1));
    endtask

    // Slave side of a read: answers the AR, then streams beats echoing the issued ID.
    task automatic serve_read(input int nbeats, input int ar_delay, input int bad_beat, input int drop_idx);
        bit ok;
        logic [IW-1:0] id;
        wait_valid(1'b0, ok);
        if (ok) begin
            repeat (ar_delay) tick();
            id = arid;
            arready = 1'b1;
            tick();
            arready = 1'b0;
            if (drop_idx >= 0) req[drop_idx] = 1'b0;
            for (int b = 0; b < nbeats; b++) begin
                rvalid = 1'b1;
                rready = 1'b1;
                rid    = (b == bad_beat) ? (id ^ 8'h01) : id;
                rlast  = (b == nbeats - 1);
                tick();
            end
            rvalid = 1'b0;
            rready = 1'b0;
            rlast  = 1'b0;
        end
    endtask

    task automatic serve_write(input int nbeats, input logic [IW-1:0] b_id, input logic [1:0] b_resp);
        bit ok;
        wait_valid(1'b1, ok);
        if (ok) begin
            awready = 1'b1;
            tick();
            awready = 1'b0;
            for (int b = 0; b < nbeats; b++) begin
                wvalid = 1'b1;
                wready = 1'b1;
                wlast  = (b == nbeats - 1);
                tick();
            end
            wvalid = 1'b0;
            wready = 1'b0;
            wlast  = 1'b0;
            chk("bready_in_bresp", 64'(bready), 64'(1));
            bvalid = 1'b1;
            bid    = b_id;
            bresp  = b_resp;
            tick();
            bvalid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if ((arvalid && arready) || (awvalid && awready)) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL addr_unexpected actual=%0h required=none", arvalid ? araddr : awaddr);
                end else begin
                    mon_ea = exp_addr_q.pop_front();
                    if (arvalid) begin
                        chk("ar_fields", 64'({1'b0, arid, araddr, arlen}), 64'(mon_ea));
                        chk("ar_consts", 64'({arsize, arburst, arlock, arcache, arprot}),
                            64'({3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
                    end else begin
                        chk("aw_fields", 64'({1'b1, awid, awaddr, awlen}), 64'(mon_ea));
                        chk("aw_consts", 64'({awsize, awburst, awlock, awcache, awprot}),
                            64'({3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
                    end
                end
            end
            if ((done | err) != '0) begin
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected actual=%0h required=none", {err, done});
                end else begin
                    mon_er = exp_resp_q.pop_front();
                    chk("resp_err_done", 64'({err, done}), 64'(mon_er));
                    chk("gnt_at_resp", 64'(gnt), 64'(mon_er[15:0] | mon_er[31:16]));
                end
            end
        end
    end

    initial begin
        int order [5];
        bit ok;
        int hs_cyc;
        order = '{0, 1, 15, 0, 1};
        reset = 1'b1;
        req = '0; req_wr = '0; req_addr = '0; req_len = '0;
        awready = 0; wvalid = 0; wready = 0; wlast = 0; bid = '0; bresp = '0; bvalid = 0;
        arready = 0; rid = '0; rresp = '0; rlast = 0; rvalid = 0; rready = 0;

        // Round-robin requesters held from reset onward.
        set_slot(0, 1'b0, 16'h1000, 8'd1);
        set_slot(1, 1'b0, 16'h1100, 8'd1);
        set_slot(15, 1'b0, 16'h1F00, 8'd1);
        req[0] = 1'b1; req[1] = 1'b1; req[15] = 1'b1;
        repeat (3) tick();
        chk("reset_state", 64'({gnt, done, err, busy, awvalid, arvalid, bready, araddr, arlen, arid}), 64'(0));
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_ar(1'b0, order[k], 16'(32'h1000 + order[k] * 256), 8'd1);
            exp_rsp(order[k], 1'b0);
        end
        for (int k = 0; k < 5; k++) serve_read(2, 0, -1, -1);
        req = '0;
        repeat (2) tick();

        // Single read with delayed arready.
        set_slot(3, 1'b0, 16'h0040, 8'd7);
        exp_ar(1'b0, 3, 16'h0040, 8'd7);
        exp_rsp(3, 1'b0);
        req[3] = 1'b1;
        tick();
        chk("grant_latency", 64'(gnt), 64'(16'h0008));
        serve_read(8, 2, -1, -1);
        chk("read_done_after_rlast", 64'(done), 64'(16'h0008));
        req[3] = 1'b0;
        tick();
        chk("gnt_drop", 64'(gnt), 64'(0));
        repeat (2) tick();

        // Single write, good response.
        set_slot(5, 1'b1, 16'h2000, 8'd3);
        exp_ar(1'b1, 5, 16'h2000, 8'd3);
        exp_rsp(5, 1'b0);
        req[5] = 1'b1;
        serve_write(4, 8'd5, 2'b00);
        req[5] = 1'b0;
        repeat (2) tick();

        // Write with SLVERR response.
        set_slot(10, 1'b1, 16'h2A00, 8'd0);
        exp_ar(1'b1, 10, 16'h2A00, 8'd0);
        exp_rsp(10, 1'b1);
        req[10] = 1'b1;
        serve_write(1, 8'd10, 2'b10);
        req[10] = 1'b0;
        repeat (2) tick();

        // Read with an RID mismatch on a middle beat.
        set_slot(6, 1'b0, 16'h3000, 8'd3);
        exp_ar(1'b0, 6, 16'h3000, 8'd3);
        exp_rsp(6, 1'b1);
        req[6] = 1'b1;
        serve_read(4, 1, 1, -1);
        req[6] = 1'b0;
        repeat (2) tick();

        // Read that never gets data: timeout.
        set_slot(9, 1'b0, 16'h3900, 8'd3);
        exp_ar(1'b0, 9, 16'h3900, 8'd3);
        exp_rsp(9, 1'b1);
        req[9] = 1'b1;
        wait_valid(1'b0, ok);
        arready = 1'b1;
        hs_cyc  = cyc;
        tick();
        arready = 1'b0;
        for (int k = 0; k < 40 && err == '0; k++) tick();
        chk("timeout_latency", 64'(cyc - hs_cyc), 64'(16));
        chk("timeout_err_idx", 64'(err), 64'(16'h0200));
        req[9] = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a read burst.
        set_slot(4, 1'b0, 16'h4000, 8'd7);
        exp_ar(1'b0, 4, 16'h4000, 8'd7);
        req[4] = 1'b1;
        wait_valid(1'b0, ok);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rready = 1'b1; rid = 8'd4; rlast = 1'b0;
            if (b == 3) reset = 1'b1;
            else tick();
        end
        #1;
        chk("reset_mid_outputs", 64'({gnt, done, err, busy, awvalid, arvalid, bready}), 64'(0));
        rvalid = 1'b0; rready = 1'b0;
        set_slot(12, 1'b0, 16'h4C00, 8'd1);
        req[12] = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        exp_ar(1'b0, 4, 16'h4000, 8'd7);
        exp_rsp(4, 1'b0);
        exp_ar(1'b0, 12, 16'h4C00, 8'd1);
        exp_rsp(12, 1'b0);
        serve_read(8, 0, -1, -1);
        req[4] = 1'b0;
        serve_read(2, 0, -1, -1);
        req[12] = 1'b0;
        repeat (2) tick();

        // Requester drops req right after the AR handshake.
        set_slot(7, 1'b0, 16'h5000, 8'd2);
        exp_ar(1'b0, 7, 16'h5000, 8'd2);
        exp_rsp(7, 1'b0);
        req[7] = 1'b1;
        serve_read(3, 1, -1, 7);
        repeat (4) tick();
        chk("no_regrant_after_drop", 64'(busy), 64'(0));

        repeat (3) tick();
        chk("addr_queue_drained", 64'(exp_addr_q.size()), 64'(0));
        chk("resp_queue_drained", 64'(exp_resp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1);
    end
endmodule

// File: doc/sync_axi_arbiter.md
Name: sync_axi_arbiter

Overview:
- Shares the single DIMM-level AXI master port between the per-bank emulation-cache sync requesters. There is one requester per (bankgroup, bank), NREQ = BANKGROUPS*BANKSPERGROUP.
- Grants round-robin, drives the AR or AW address channel for the granted request, then tracks completion (last R beat, or B response).
- Returns a one-cycle done/err pulse to the requester.
- W and R data beats are moved by the granted requester; this block only observes them.

Parameters:
- NREQ, 16, number of requesters (flat index = bg*BANKSPERGROUP+ba).
- AXI_ADDR_WIDTH, 16, AXI address width.
- AXI_DATA_WIDTH, 32, AXI data width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width.
- AXI_ID_WIDTH, 8, ID width; must be >= clog2(NREQ).
- TIMEOUT, 1024, cycles allowed from address handshake to completion.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester transfer request, held until done or err.
- req_wr  in  NREQ  1 = writeback (AW/W/B), 0 = fill (AR/R).
- req_addr  in  NREQ*AXI_ADDR_WIDTH  flat start address; slot i at [i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH].
- req_len  in  NREQ*8  flat AXI burst length (beats-1).
- gnt  out  NREQ  one-hot grant; high from grant cycle through the done/err cycle.
- done  out  NREQ  one-hot, one-cycle successful-completion pulse.
- err  out  NREQ  one-hot, one-cycle failure pulse.
- busy  out  1  high whenever FSM is not IDLE.
- m_axi_aw*  out  AXI  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid.
- m_axi_awready  in  1  AW handshake.
- m_axi_wvalid, m_axi_wready, m_axi_wlast  in  1 each  observed only.
- m_axi_bid  in  AXI_ID_WIDTH  write response ID.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_ar*  out  AXI  same field set as AW.
- m_axi_arready  in  1  AR handshake.
- m_axi_rid  in  AXI_ID_WIDTH  read ID.
- m_axi_rresp  in  2  read response.
- m_axi_rlast, m_axi_rvalid, m_axi_rready  in  1 each  observed; rready is driven by the requester.

Behaviour:
- Reset:
  - FSM = IDLE, rr pointer = 0.
  - gnt, done, err, busy, awvalid, arvalid, bready = 0; captured addr/len/id = 0.
  - Reset mid-transfer drops valid/ready immediately. No done/err is emitted.
- Constant outputs: awsize/arsize = clog2(AXI_STRB_WIDTH), burst = 2'b01 (INCR), lock = 0, cache = 4'b0011, prot = 3'b000.
- IDLE:
  - Select the first asserted req at or after rr pointer, wrapping modulo NREQ.
  - Register gnt, index, wr, addr, len. ID = zero-extended index.
  - Go to ADDR.
  - Grant latency: one cycle from req seen to gnt high.
- ADDR:
  - Assert awvalid (wr=1) or arvalid (wr=0); address fields are stable while valid.
  - On ready: drop valid, clear timer. Go to WDATA (wr=1) or RDATA (wr=0).
  - No timeout applies while waiting for ready.
- WDATA: wait for a wvalid&wready&wlast handshake, then go to BRESP. Timer runs.
- BRESP:
  - bready = 1.
  - On bvalid: success if bresp[1]==0 and bid==ID, otherwise fail. Go to FINISH.
- RDATA:
  - Latch a sticky fail on any R handshake with rresp[1]==1 or rid!=ID.
  - On an R handshake with rlast, go to FINISH.
- Timeout: timer increments in WDATA/BRESP/RDATA. When the timer reaches TIMEOUT-1, force fail and go to FINISH.
- FINISH (one cycle):
  - Pulse done[index] (success) or err[index] (fail). gnt stays high this cycle.
  - rr pointer = (index+1) mod NREQ. Go to IDLE; gnt drops next cycle.
- Requester deasserting req mid-transfer: ignored; the transfer completes normally.
- New req while busy: held pending; arbitrated in the next IDLE.
- Back-to-back: minimum 3 idle cycles between successive address valids (FINISH, IDLE, then ADDR).
- A 1-beat read (len=0) with rlast on its first beat is legal.
- An R or W handshake in the same cycle as the AR/AW handshake is not counted; a compliant slave cannot produce one.

Test Plan:
- Single read: req[3]=1, req_wr[3]=0, addr=0x0040, len=7; arready after 2 cycles, 8 R beats with rid=3 and rlast on beat 8 -> araddr=0x0040, arlen=7, arid=3; done[3] pulses the cycle after rlast; gnt[3] then drops.
- Single write: req[5]=1, wr=1, len=3; 4 W beats, then bvalid with bid=5, bresp=0 -> awid=5; bready=1 in BRESP; done[5] pulse; no err.
- Round-robin: req[0], req[1], req[15] held continuously from reset -> grant order 0,1,15,0,1,...; each grant completes before the next.
- Error paths:
  - bresp=2'b10 -> err pulse, no done.
  - rid mismatch on a middle beat -> err after rlast.
  - TIMEOUT=16 with no R beats -> err[i] exactly 16 cycles after the AR handshake.
- Reset mid-RDATA: assert reset on the 4th beat -> all outputs 0 in the same cycle; after release, a pending req is regranted starting from index 0.
- Req drop: requester deasserts req after the AR handshake -> transfer still completes; done pulses; no spurious regrant.
